// File: rtl/data_sram_responder_pkg.sv
// rtl/data_sram_responder_pkg.sv - shared size encodings, latency range and lane-mask helper
package data_sram_responder_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;
    localparam int OUTST_W     = $clog2(LATENCY_MAX + 1);

    // Lanes a request of this size may legally touch at this byte offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_B:    m = 4'b0001 << off;
            SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_sram_responder_resp_delay_line.sv
// rtl/data_sram_responder_resp_delay_line.sv - fixed-latency valid+data shift register for responses
module resp_delay_line #(
    parameter int LATENCY = 2,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic [LATENCY-1:0] valid_q;
    logic [DW-1:0]      data_q [LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Data needs no reset: it is only observed alongside its valid bit.
    always_ff @(posedge clk) begin
        data_q[0] <= valid_i ? data_i : '0;
        for (int i = 1; i < LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - fixed-latency data SRAM responder; DATA_SRAM_RAND_STALL_EN adds LFSR stalls
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int AW        = 10,
    parameter int LATENCY   = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        proto_err
);

    localparam int LAT_C = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                           (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam logic [OUTST_W-1:0] MAX_OUTST_C = OUTST_W'(MAX_OUTST);

    logic [31:0]        mem_q [2**AW];
    logic [OUTST_W-1:0] outst_q, outst_d;
    logic               perr_q, perr_d;
    logic               dl_valid;
    logic [31:0]        dl_data;
    logic               stall;
    logic [AW-1:0]      idx;
    logic [3:0]         mask;
    logic               misalign;
    logic               req_err;
    logic               accept;
    logic               unused_addr_hi;

    assign idx            = data_sram_addr[AW+1:2];
    assign unused_addr_hi = ^data_sram_addr[31:AW+2];
    assign mask           = lane_mask(data_sram_size, data_sram_addr[1:0]);
    assign misalign       = (data_sram_size == SZ_H && data_sram_addr[0]) ||
                            (data_sram_size == SZ_W && data_sram_addr[1:0] != 2'd0);
    assign req_err        = (data_sram_size == 2'd3) || misalign ||
                            (data_sram_wr && |(data_sram_wstrb & ~mask));

`ifdef DATA_SRAM_RAND_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'h0001;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // A response retiring this cycle frees its slot for a same-cycle acceptance.
    assign data_sram_addr_ok = !stall &&
                               ((outst_q < MAX_OUTST_C) || (outst_q == MAX_OUTST_C && dl_valid));
    assign accept            = data_sram_req && data_sram_addr_ok && !reset;

    always_comb begin
        outst_d = outst_q;
        perr_d  = perr_q;
        case ({accept, dl_valid})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
        if (accept && req_err) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outst_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            outst_q <= outst_d;
            perr_q  <= perr_d;
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    mem_q[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    resp_delay_line #(
        .LATENCY (LAT_C),
        .DW      (32)
    ) u_resp_delay_line (
        .clk     (clk),
        .reset   (reset),
        .valid_i (accept),
        .data_i  (data_sram_wr ? 32'h0 : mem_q[idx]),
        .valid_o (dl_valid),
        .data_o  (dl_data)
    );

    assign data_sram_data_ok = dl_valid;
    assign data_sram_rdata   = dl_valid ? dl_data : 32'h0;
    assign proto_err         = perr_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - vector table, directed corner sequences and randomized model check
module tb_data_sram_responder;

    localparam int LAT  = 2;
    localparam int MOUT = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        aok, dok, perr;
    logic [31:0] rdata;

    logic        r1_req;
    logic        a1_aok, a1_dok, a1_perr;
    logic [31:0] a1_rdata;

    data_sram_responder #(.AW(10), .LATENCY(LAT), .MAX_OUTST(MOUT)) u_dut (
        .clk               (clk),
        .reset             (reset),
        .data_sram_req     (req),
        .data_sram_wr      (wr),
        .data_sram_size    (size),
        .data_sram_addr    (addr),
        .data_sram_wstrb   (wstrb),
        .data_sram_wdata   (wdata),
        .data_sram_addr_ok (aok),
        .data_sram_data_ok (dok),
        .data_sram_rdata   (rdata),
        .proto_err         (perr)
    );

    data_sram_responder #(.AW(10), .LATENCY(2), .MAX_OUTST(1)) u_dut1 (
        .clk               (clk),
        .reset             (reset),
        .data_sram_req     (r1_req),
        .data_sram_wr      (1'b0),
        .data_sram_size    (2'd2),
        .data_sram_addr    (32'h0000_0100),
        .data_sram_wstrb   (4'h0),
        .data_sram_wdata   (32'h0),
        .data_sram_addr_ok (a1_aok),
        .data_sram_data_ok (a1_dok),
        .data_sram_rdata   (a1_rdata),
        .proto_err         (a1_perr)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_perr;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc   = 0;
    resp_t       q_m[$];
    logic [31:0] mem_m [1024];
    logic        perr_m = 1'b0;
    logic        acc_m;
    logic        s_dok, s_aok, s_perr, d1_aok, d1_dok;
    logic [31:0] s_rdata;
    vec_t        vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic bit model_err(input logic w, input int sz, input logic [31:0] a,
                                     input logic [3:0] st);
        int          off;
        int          nb;
        logic [3:0]  allowed;
        off = int'(a & 32'd3);
        if (sz == 3) return 1'b1;
        if (off % (1 << sz) != 0) return 1'b1;
        nb      = 1 << sz;
        allowed = 4'(((1 << nb) - 1) << off);
        return w && ((st & ~allowed) != 4'h0);
    endfunction

    task automatic tick(input bit chk);
        logic        exp_dok, exp_aok;
        logic [31:0] exp_rd;
        int          idx;
        bit          err;
        @(negedge clk);
        s_dok   = dok;
        s_aok   = aok;
        s_rdata = rdata;
        s_perr  = perr;
        d1_aok  = a1_aok;
        d1_dok  = a1_dok;
        exp_dok = (q_m.size() > 0) && (q_m[0].due == cyc);
        exp_rd  = exp_dok ? q_m[0].data : 32'h0;
        exp_aok = (q_m.size() < MOUT) || (q_m.size() == MOUT && exp_dok);
        if (chk) begin
            check("data_ok", dok, exp_dok);
            check("addr_ok", aok, exp_aok);
            check("rdata", rdata, exp_rd);
            check("proto_err", perr, perr_m);
        end
        acc_m = 1'b0;
        if (reset) begin
            q_m.delete();
            perr_m = 1'b0;
        end else begin
            if (exp_dok) void'(q_m.pop_front());
            if (req && exp_aok) begin
                acc_m = 1'b1;
                idx   = int'((addr >> 2) % 1024);
                err   = model_err(wr, int'(size), addr, wstrb);
                q_m.push_back('{due: cyc + LAT, data: wr ? 32'h0 : mem_m[idx]});
                if (err) begin
                    perr_m = 1'b1;
                end else if (wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [3:0] st, input logic [31:0] d);
        req = 1'b1; wr = w; size = sz; addr = a; wstrb = st; wdata = d;
    endtask

    initial begin
        int          lat, cnt, outst1;
        bit          seen;
        logic [31:0] got;
        logic        p_acc, p_next, prev_perr;

        vecs[0] = '{1'b1, 2'd2, 32'h0000_0100, 4'hF, 32'h1234_5678, 32'h0,          1'b0};
        vecs[1] = '{1'b0, 2'd2, 32'h0000_0100, 4'h0, 32'h0,          32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 2'd0, 32'h0000_0101, 4'h2, 32'h0000_AB00, 32'h0,          1'b0};
        vecs[3] = '{1'b0, 2'd2, 32'h0000_0100, 4'h0, 32'h0,          32'h1234_AB78, 1'b0};
        vecs[4] = '{1'b0, 2'd2, 32'h1000_0100, 4'h0, 32'h0,          32'h1234_AB78, 1'b0};
        vecs[5] = '{1'b1, 2'd1, 32'h0000_0102, 4'hC, 32'hBEEF_0000, 32'h0,          1'b0};
        vecs[6] = '{1'b0, 2'd2, 32'h0000_0100, 4'h0, 32'h0,          32'hBEEF_AB78, 1'b0};
        vecs[7] = '{1'b0, 2'd2, 32'h0000_0102, 4'h0, 32'h0,          32'hBEEF_AB78, 1'b1};
        vecs[8] = '{1'b1, 2'd0, 32'h0000_0100, 4'hF, 32'hFFFF_FFFF, 32'h0,          1'b1};
        vecs[9] = '{1'b0, 2'd2, 32'h0000_0100, 4'h0, 32'h0,          32'hBEEF_AB78, 1'b1};

        reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; addr = 32'h0;
        wstrb = 4'h0; wdata = 32'h0; r1_req = 1'b0;
        tick(0);
        tick(0);
        reset = 1'b0;
        tick(1);
        check("rst_addr_ok", s_aok, 32'd1);
        check("rst_data_ok", s_dok, 32'd0);
        check("rst_proto_err", s_perr, 32'd0);

        prev_perr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_req(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata);
            tick(1);
            check("vec_accept", s_aok & req, 32'd1);
            p_acc = s_perr;
            req = 1'b0;
            seen = 1'b0; lat = 0; got = 32'h0; p_next = 1'b0;
            for (int k = 1; k <= 10 && !seen; k++) begin
                tick(1);
                if (k == 1) p_next = s_perr;
                if (s_dok) begin
                    seen = 1'b1; lat = k; got = s_rdata;
                end
            end
            check("vec_latency", lat, LAT);
            check("vec_rdata", got, vecs[i].exp_rdata);
            check("vec_perr_at_accept", p_acc, prev_perr);
            check("vec_perr_next", p_next, vecs[i].exp_perr);
            prev_perr = vecs[i].exp_perr;
        end

        // Clear the sticky error before the remaining sequences.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;

        // Store then load the same word on consecutive cycles.
        set_req(1'b1, 2'd2, 32'h0000_0200, 4'hF, 32'hCAFE_F00D);
        tick(1);
        set_req(1'b0, 2'd2, 32'h0000_0200, 4'h0, 32'h0);
        tick(1);
        check("b2b_load_accept", s_aok, 32'd1);
        req = 1'b0;
        cnt = 0; got = 32'h0;
        for (int k = 0; k < 10 && cnt < 2; k++) begin
            tick(1);
            if (s_dok) begin
                cnt++;
                got = s_rdata;
            end
        end
        check("b2b_responses", cnt, 32'd2);
        check("b2b_rdata", got, 32'hCAFE_F00D);

        // Two loads in flight, then reset: nothing may come back.
        set_req(1'b0, 2'd2, 32'h0000_0100, 4'h0, 32'h0);
        tick(1);
        tick(1);
        req = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        check("post_rst_addr_ok", s_aok, 32'd1);
        check("post_rst_data_ok", s_dok, 32'd0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (s_dok) cnt++;
        end
        check("post_rst_no_resp", cnt, 32'd0);

        // MAX_OUTST=1 instance with request held high.
        r1_req = 1'b1;
        outst1 = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("mo1_addr_ok", d1_aok, (i % 2 == 0));
            check("mo1_data_ok", d1_dok, (i >= 2 && i % 2 == 0));
            outst1 = outst1 + int'(d1_aok) - int'(d1_dok);
            check("mo1_outst_le1", (outst1 <= 1 && outst1 >= 0), 32'd1);
        end
        r1_req = 1'b0;
        for (int k = 0; k < 4; k++) tick(1);

        // Initialise the random window so every load has a known answer.
        for (int i = 0; i < 16; i++) begin
            set_req(1'b1, 2'd2, 32'h0000_0100 + 32'(4 * i), 4'hF, $urandom);
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                tick(1);
                seen = acc_m;
            end
            check("fill_accept", seen, 32'd1);
        end
        req = 1'b0;
        for (int k = 0; k < 4; k++) tick(1);

        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            req   = $urandom_range(0, 1);
            wr    = $urandom_range(0, 1);
            size  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr  = ($urandom & 32'hFFFF_F000) | (32'h0000_0100 + 32'($urandom_range(0, 63)));
            wstrb = 4'($urandom);
            wdata = $urandom;
            tick(1);
        end
        reset = 1'b0;
        req   = 1'b0;
        for (int k = 0; k < 6; k++) tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 Parameters SHALL be, one per line:
- AW, 10, word-address width; array holds 2^AW 32-bit words.
- LATENCY, 2, cycles from request acceptance to data_ok; legal 1..4.
- MAX_OUTST, 2, maximum accepted-but-unanswered requests; legal 1..LATENCY.
REQ-003 Ports SHALL be, one per line:
- data_sram_req  input  1  request valid.
- data_sram_wr  input  1  1=store, 0=load.
- data_sram_size  input  2  0=byte, 1=half, 2=word.
- data_sram_addr  input  32  byte address.
- data_sram_wstrb  input  4  byte-lane write enables.
- data_sram_wdata  input  32  store data.
- data_sram_addr_ok  output  1  request accepted this cycle when high with req.
- data_sram_data_ok  output  1  response valid, one-cycle pulse per request.
- data_sram_rdata  output  32  full aligned word read; zero for stores.
- proto_err  output  1  sticky protocol-violation flag.

Function
REQ-004 A request SHALL be accepted on a rising edge where data_sram_req && data_sram_addr_ok.
REQ-005 Array index SHALL be data_sram_addr[AW+1:2]; upper address bits ignored (wrap-around); addr[1:0] never shifts data.
REQ-006 A store SHALL update exactly the lanes set in data_sram_wstrb at the acceptance edge; wstrb==0 writes nothing.
REQ-007 A load SHALL sample the word at the acceptance edge, so a load accepted the cycle after a store to the same word returns the new data.
REQ-008 data_ok SHALL pulse exactly LATENCY cycles after acceptance, responses in acceptance order, at most one per cycle; the requester cannot backpressure data_ok.
REQ-009 An outstanding counter SHALL increment on acceptance, decrement on data_ok, hold when both occur in the same cycle, and never exceed MAX_OUTST.
REQ-010 addr_ok SHALL be high iff counter < MAX_OUTST, or counter == MAX_OUTST and data_ok is high this cycle; it is combinational from state only, never from data_sram_req.
REQ-011 proto_err SHALL set on acceptance when any of these hold, and stay set until reset:
- size==3.
- Misaligned: size==1 with addr[0]==1, or size==2 with addr[1:0]!=0.
- Store with a wstrb bit outside the lanes implied by size/addr[1:0].
REQ-012 An erroneous request SHALL still be accepted and answered; a store with an error SHALL write nothing.
REQ-013 data_sram_rdata SHALL be 0 whenever data_ok is low.

Reset
REQ-014 On reset, data_ok, proto_err, the counter and all response-pipeline valid bits SHALL be 0, and addr_ok SHALL be 1.
REQ-015 Array contents SHALL NOT be reset; stores accepted before a mid-operation reset remain in the array, and their in-flight responses SHALL be discarded.
REQ-016 No request SHALL be accepted in a cycle where reset is high.

Configuration
REQ-017 Macro DATA_SRAM_RAND_STALL_EN:
- When defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'h0001, advances every cycle) additionally forces addr_ok low when its bit 0 is 1.
- When undefined: addr_ok follows REQ-010 only, and the LFSR SHALL NOT exist.

Structure
REQ-018 The size encodings (SZ_B/SZ_H/SZ_W), the LATENCY legal range and the lane-mask function (size, addr[1:0]) -> 4-bit mask SHALL live in the shared header/package.
REQ-019 The response delay line (LATENCY-stage valid+data shift register) SHALL be one sub-module named resp_delay_line; the array, counter, checker and LFSR stay in the top module.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Store word 0x12345678 to 0x100 (wstrb=F), then load 0x100: with LATENCY=2, data_ok 2 cycles after each acceptance; load returns 0x12345678.
- Store byte 0xAB to 0x101 (size=0, wstrb=2), load 0x100: returns 0x1234AB78; proto_err stays 0.
- req held high for 6 cycles with MAX_OUTST=1, LATENCY=2: acceptances exactly every 2 cycles; counter never exceeds 1.
- Load size=2 at 0x102: proto_err rises the cycle after acceptance; data_ok still returned; an erroneous store leaves memory unchanged.
- Reset asserted with 2 loads in flight: no data_ok afterwards; counter 0; addr_ok 1 the cycle after reset deasserts.
- Address 0x1000_0100 with AW=10: aliases word 0x100.
